ccff_bitstream_loader: RTL

- Upstream feeder for the tile configuration chains: accepts parallel bitstream words from the SoC-side host over a valid/ready handshake.
- Serialises each word onto NUM_CHAINS parallel ccff_head chains (e.g. ccff_head, ccff_head_1 of the bottom-row tiles), one bit per chain per shift.
- Drives a shift enable that gates prog_clk to the fabric.
- Captures the returning ccff_tail bits into readback words for bitstream verification.

---
 rtl/ccff_loader_pkg.sv | 20 ++
 rtl/ccff_bitstream_loader_if.sv | 11 +
 rtl/ccff_tail_capture.sv | 56 +++++
 rtl/ccff_bitstream_loader.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/ccff_loader_pkg.sv
// Shared types and sizing helpers for the configuration-chain bitstream loader.
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    // Shifts needed to drain one host word across all chains.
    function automatic int unsigned spw(input int unsigned word_w, input int unsigned num_chains);
        return word_w / num_chains;
    endfunction

    // Width of the slice index; never below one bit.
    function automatic int unsigned idx_w(input int unsigned slices);
        return (slices > 1) ? $clog2(slices) : 1;
    endfunction

endpackage

// File: rtl/ccff_bitstream_loader_if.sv
// Host-side valid/ready word stream into the loader.
interface ccff_bitstream_loader_if #(
    parameter int unsigned WORD_W = 32
) ();
    logic              s_valid;
    logic              s_ready;
    logic [WORD_W-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/ccff_tail_capture.sv
// Collects returning ccff_tail bits into a readback word at the same slice
// positions as the outgoing data and publishes it one cycle after completion.
module ccff_tail_capture
    import ccff_loader_pkg::*;
#(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned NUM_CHAINS = 2,
    localparam int unsigned SPW       = spw(WORD_W, NUM_CHAINS),
    localparam int unsigned IDX_W     = idx_w(SPW)
) (
    input  logic                  prog_clk,
    input  logic                  prog_reset,
    input  logic                  shift,
    input  logic [IDX_W-1:0]      slice,
    input  logic [NUM_CHAINS-1:0] tail_bits,
    input  logic                  emit,
    input  logic                  clear,
    output logic                  tail_valid,
    output logic [WORD_W-1:0]     tail_data
);

    logic [SPW-1:0][NUM_CHAINS-1:0] tail_q, tail_d, merged;
    logic                           tail_valid_q;
    logic [WORD_W-1:0]              tail_data_q;

    // Merge this cycle's tail slice; restart from zero after each emitted word.
    always_comb begin
        merged = tail_q;
        if (shift) begin
            merged[slice] = tail_bits;
        end
        tail_d = merged;
        if (emit || clear) begin
            tail_d = '0;
        end
    end

    // Tail register, published word and its one-cycle valid pulse.
    always_ff @(posedge prog_clk or negedge prog_reset) begin
        if (!prog_reset) begin
            tail_q       <= '0;
            tail_valid_q <= 1'b0;
            tail_data_q  <= '0;
        end else begin
            tail_q       <= tail_d;
            tail_valid_q <= emit;
            if (emit) begin
                tail_data_q <= merged;
            end
        end
    end

    assign tail_valid = tail_valid_q;
    assign tail_data  = tail_data_q;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serialises host bitstream words onto parallel ccff_head chains, gates the
// fabric prog_clk via shift_en and gathers ccff_tail readback words.
module ccff_bitstream_loader
    import ccff_loader_pkg::*;
#(
    parameter int unsigned WORD_W     = 32,
    parameter int unsigned NUM_CHAINS = 2,
    parameter int unsigned LEN_W      = 20
) (
    input  logic                    prog_clk,
    input  logic                    prog_reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [LEN_W-1:0]        cfg_len,
    ccff_bitstream_loader_if.slave  host,
    output logic [NUM_CHAINS-1:0]   ccff_head_o,
    input  logic [NUM_CHAINS-1:0]   ccff_tail_i,
    output logic                    shift_en,
    output logic                    busy,
    output logic                    done,
    output logic                    stall,
    output logic                    tail_valid,
    output logic [WORD_W-1:0]       tail_data
);

    localparam int unsigned      SPW      = spw(WORD_W, NUM_CHAINS);
    localparam int unsigned      IDX_W    = idx_w(SPW);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SPW - 1);

    state_e                         state_q, state_d;
    logic                           buf_valid_q, buf_valid_d;
    logic [SPW-1:0][NUM_CHAINS-1:0] buf_q, buf_d;
    logic [IDX_W-1:0]               slice_q, slice_d;
    logic [LEN_W-1:0]               remaining_q, remaining_d;

    logic shift, last_slice, final_shift, word_end, ready, accept;

    // Shift qualification and the zero-bubble refill window.
    always_comb begin
        shift       = (state_q == StShift) && buf_valid_q && !abort;
        last_slice  = (slice_q == LAST_IDX);
        final_shift = shift && (remaining_q == LEN_W'(1));
        word_end    = shift && last_slice;
        ready       = !abort && (state_q == StShift)
                      && (!buf_valid_q || (word_end && (remaining_q > LEN_W'(1))));
        accept      = host.s_valid && ready;
    end

    // Next-state logic for FSM, word buffer and counters; abort overrides all.
    always_comb begin
        state_d     = state_q;
        buf_valid_d = buf_valid_q;
        buf_d       = buf_q;
        slice_d     = slice_q;
        remaining_d = remaining_q;
        if (abort) begin
            state_d     = StIdle;
            buf_valid_d = 1'b0;
            buf_d       = '0;
            slice_d     = '0;
            remaining_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (cfg_len != '0) begin
                            state_d     = StShift;
                            remaining_d = cfg_len;
                        end else begin
                            state_d = StDone;
                        end
                    end
                end
                StShift: begin
                    if (shift) begin
                        remaining_d = remaining_q - LEN_W'(1);
                        slice_d     = slice_q + IDX_W'(1);
                        // Leftover slices of a partial last word are dropped.
                        if (final_shift) begin
                            state_d     = StDone;
                            buf_valid_d = 1'b0;
                            buf_d       = '0;
                            slice_d     = '0;
                        end else if (last_slice) begin
                            buf_valid_d = 1'b0;
                            slice_d     = '0;
                        end
                    end
                    if (accept) begin
                        buf_valid_d = 1'b1;
                        buf_d       = host.s_data;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State, buffer and counter registers.
    always_ff @(posedge prog_clk or negedge prog_reset) begin
        if (!prog_reset) begin
            state_q     <= StIdle;
            buf_valid_q <= 1'b0;
            buf_q       <= '0;
            slice_q     <= '0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
            buf_q       <= buf_d;
            slice_q     <= slice_d;
            remaining_q <= remaining_d;
        end
    end

    // Head data follows the buffer directly so it lines up with shift_en.
    always_comb begin
        ccff_head_o = shift ? buf_q[slice_q] : '0;
    end

    assign host.s_ready = ready;
    assign shift_en     = shift;
    assign busy         = (state_q == StShift);
    assign stall        = (state_q == StShift) && !buf_valid_q;
    assign done         = (state_q == StDone) && !abort;

    ccff_tail_capture #(
        .WORD_W    (WORD_W),
        .NUM_CHAINS(NUM_CHAINS)
    ) u_tail_capture (
        .prog_clk  (prog_clk),
        .prog_reset(prog_reset),
        .shift     (shift),
        .slice     (slice_q),
        .tail_bits (ccff_tail_i),
        .emit      (word_end || final_shift),
        .clear     (abort),
        .tail_valid(tail_valid),
        .tail_data (tail_data)
    );

endmodule
